// File: rtl/pixel_fb_scanout.sv
// Pixel-write receiver with a 160x120x3 frame buffer, scanned out as VGA with
// every stored pixel replicated 4x4. A post-reset CLEAR pass fills the buffer.
`timescale 1ns/1ps

module pixel_fb_scanout #(
   parameter logic [2:0] BG_COLOUR = 3'b000,
   parameter int         H_VIS     = 640,
   parameter int         H_FP      = 16,
   parameter int         H_SYNC    = 96,
   parameter int         H_BP      = 48,
   parameter int         V_VIS     = 480,
   parameter int         V_FP      = 10,
   parameter int         V_SYNC    = 2,
   parameter int         V_BP      = 33
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       plot,
   input  logic [7:0] x,
   input  logic [6:0] y,
   input  logic [2:0] colour,
   output logic       ready,
   output logic       frame_done,
   output logic       vga_clk,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic       vga_sync_n,
   output logic [9:0] vga_r,
   output logic [9:0] vga_g,
   output logic [9:0] vga_b
);

   localparam int FB_SIZE = 160 * 120;
   localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [14:0] CLR_LAST   = 15'(FB_SIZE - 1);
   localparam logic [9:0]  H_LAST     = 10'(H_TOT - 1);
   localparam logic [9:0]  V_LAST     = 10'(V_TOT - 1);
   localparam logic [9:0]  H_VIS_W    = 10'(H_VIS);
   localparam logic [9:0]  V_VIS_W    = 10'(V_VIS);
   localparam logic [9:0]  H_SYNC_BEG = 10'(H_VIS + H_FP);
   localparam logic [9:0]  H_SYNC_END = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0]  V_SYNC_BEG = 10'(V_VIS + V_FP);
   localparam logic [9:0]  V_SYNC_END = 10'(V_VIS + V_FP + V_SYNC);

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

   state_t      state_reg;
   logic [14:0] clr_addr_reg;
   logic        pix_en_reg;
   logic        vga_clk_reg;
   logic        frame_done_reg;
   logic [9:0]  h_reg;
   logic [9:0]  v_reg;
   logic        hs1_reg, vs1_reg, vis1_reg;
   logic        hs_reg, vs_reg, blank_n_reg;
   logic [2:0]  rgb_reg;
   logic [2:0]  rd_data_reg;
   logic [2:0]  mem [0:FB_SIZE-1];

   logic        vis;
   logic [14:0] row_rd, row_wr;
   logic [14:0] rd_addr, plot_addr, wr_addr;
   logic        plot_ok, wr_en;
   logic [2:0]  wr_data;

   // Addresses are y*160+x built from shifts; reads outside the visible area
   // are parked at 0 so the index never leaves the buffer.
   always_comb begin
      vis       = (h_reg < H_VIS_W) && (v_reg < V_VIS_W);
      row_rd    = {7'd0, v_reg[9:2]};
      row_wr    = {8'd0, y};
      rd_addr   = vis ? (row_rd << 7) + (row_rd << 5) + {7'd0, h_reg[9:2]} : '0;
      plot_addr = (row_wr << 7) + (row_wr << 5) + {7'd0, x};
      plot_ok   = plot && (x < 8'd160) && (y < 7'd120);
      wr_en     = plot_ok;
      wr_addr   = plot_addr;
      wr_data   = colour;
      if (state_reg == CLEAR) begin
         wr_en   = 1'b1;
         wr_addr = clr_addr_reg;
         wr_data = BG_COLOUR;
      end
   end

   // Read-before-write: a same-clk write to the address being read is seen next frame.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (pix_en_reg)
         rd_data_reg <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= CLEAR;
         clr_addr_reg <= '0;
      end else if (state_reg == CLEAR) begin
         if (clr_addr_reg == CLR_LAST) begin
            state_reg    <= RUN;
            clr_addr_reg <= '0;
         end else begin
            clr_addr_reg <= clr_addr_reg + 15'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pix_en_reg     <= 1'b0;
         vga_clk_reg    <= 1'b0;
         frame_done_reg <= 1'b0;
         h_reg          <= '0;
         v_reg          <= '0;
         hs1_reg        <= 1'b1;
         vs1_reg        <= 1'b1;
         vis1_reg       <= 1'b0;
      end else begin
         pix_en_reg     <= ~pix_en_reg;
         vga_clk_reg    <= pix_en_reg;
         frame_done_reg <= 1'b0;
         if (pix_en_reg) begin
            frame_done_reg <= (h_reg == 10'd0) && (v_reg == V_VIS_W);
            hs1_reg        <= !((h_reg >= H_SYNC_BEG) && (h_reg < H_SYNC_END));
            vs1_reg        <= !((v_reg >= V_SYNC_BEG) && (v_reg < V_SYNC_END));
            vis1_reg       <= vis;
            if (h_reg == H_LAST) begin
               h_reg <= '0;
               v_reg <= (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
            end else begin
               h_reg <= h_reg + 10'd1;
            end
         end
      end
   end

   // Second stage: sync/blank wait one pixel period so they line up with RAM data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hs_reg      <= 1'b1;
         vs_reg      <= 1'b1;
         blank_n_reg <= 1'b0;
         rgb_reg     <= '0;
      end else if (pix_en_reg) begin
         hs_reg      <= hs1_reg;
         vs_reg      <= vs1_reg;
         blank_n_reg <= vis1_reg && (state_reg == RUN);
         rgb_reg     <= (vis1_reg && (state_reg == RUN)) ? rd_data_reg : 3'b000;
      end
   end

   assign ready       = (state_reg == RUN);
   assign frame_done  = frame_done_reg;
   assign vga_clk     = vga_clk_reg;
   assign vga_hs      = hs_reg;
   assign vga_vs      = vs_reg;
   assign vga_blank_n = blank_n_reg;
   assign vga_sync_n  = 1'b1;

   for (genvar gi = 0; gi < 10; gi++) begin : g_dac
      assign vga_r[gi] = rgb_reg[2];
      assign vga_g[gi] = rgb_reg[1];
      assign vga_b[gi] = rgb_reg[0];
   end

endmodule

// File: tb/tb_pixel_fb_scanout.sv
// Randomized bench for pixel_fb_scanout on a shrunken raster: every clk the
// outputs are compared against an image/timing model derived from the frame rules.
`timescale 1ns/1ps

module tb_pixel_fb_scanout;

   localparam logic [2:0] BG = 3'b001;
   localparam int H_VIS = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
   localparam int V_VIS = 32, V_FP = 2, V_SYNC = 2, V_BP = 4;
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int FRAME_PIX = H_TOT * V_TOT;
   localparam int FRAME_CLK = 2 * FRAME_PIX;
   localparam int CLEAR_CLK = 19200;

   logic clk = 1'b0;
   logic resetn, plot;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic ready, frame_done, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
   logic [9:0] vga_r, vga_g, vga_b;

   pixel_fb_scanout #(
      .BG_COLOUR(BG),
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .clk(clk), .resetn(resetn), .plot(plot), .x(x), .y(y), .colour(colour),
      .ready(ready), .frame_done(frame_done), .vga_clk(vga_clk),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct { int e; int x; int y; logic [2:0] c; } wr_t;
   wr_t pend[$];
   logic [2:0] img [0:19199];
   bit img_fresh = 0;

   logic [36:0] obs;
   assign obs = {ready, frame_done, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
                 vga_r, vga_g, vga_b};

   function automatic logic [36:0] pack(input bit rdy, input bit fd, input bit vc,
                                        input bit hs, input bit vs, input bit bl,
                                        input logic [2:0] rgb);
      return {rdy, fd, vc, hs, vs, bl, 1'b1, {10{rgb[2]}}, {10{rgb[1]}}, {10{rgb[0]}}};
   endfunction

   localparam logic [36:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 30'd0};

   task automatic check(input string tag, input logic [36:0] got, input logic [36:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s at cyc %0d: got %h expected %h", tag, cyc, got, want);
      end
   endtask

   // Clock edges since reset release; edge n is the n-th posedge with resetn high.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   // Fold in every write sampled before edge r; writes are only taken once
   // the clear pass is over and only inside the 160x120 buffer.
   task automatic apply_until(input int r);
      while (pend.size() > 0 && pend[0].e < r) begin
         if (pend[0].e > CLEAR_CLK && pend[0].x < 160 && pend[0].y < 120)
            img[pend[0].y * 160 + pend[0].x] = pend[0].c;
         void'(pend.pop_front());
      end
   endtask

   // Pixel period p occupies edges 2p+1..2p+2; its read happens at edge 2p+2
   // and the scan outputs show it from edge 2p+4 on.
   function automatic logic [36:0] expected(input int n);
      int m, p, h, v;
      bit fd, hs, vs, vis;
      logic [2:0] rgb;
      fd = 0;
      if (n >= 2 && n % 2 == 0) begin
         p  = (n - 2) / 2;
         fd = (p % H_TOT == 0) && ((p / H_TOT) % V_TOT == V_VIS);
      end
      m = n - (n % 2);
      hs = 1; vs = 1; vis = 0; rgb = 3'b000;
      if (m >= 4) begin
         p   = (m - 4) / 2;
         h   = p % H_TOT;
         v   = (p / H_TOT) % V_TOT;
         hs  = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
         vs  = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
         vis = (h < H_VIS) && (v < V_VIS) && (m > CLEAR_CLK);
         if (vis) rgb = img[(v / 4) * 160 + h / 4];
      end
      return pack(n >= CLEAR_CLK, fd, (n >= 2 && n % 2 == 0), hs, vs, vis, rgb);
   endfunction

   always @(negedge clk) begin
      if (!resetn) begin
         if (!img_fresh) begin
            foreach (img[i]) img[i] = BG;
            pend.delete();
            img_fresh = 1;
         end
         check("reset_hold", obs, RESET_VEC);
      end else begin
         img_fresh = 0;
         apply_until(cyc - (cyc % 2) - 2);
         check("scan", obs, expected(cyc));
      end
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
      check("schedule", 37'(cyc), 37'(t));
   endtask

   task automatic do_plot(input int xx, input int yy, input logic [2:0] cc);
      plot = 1'b1; x = 8'(xx); y = 7'(yy); colour = cc;
      pend.push_back('{cyc + 1, xx, yy, cc});
      $display("plot x=%0d y=%0d colour=%b at edge %0d", xx, yy, cc, cyc + 1);
      @(negedge clk);
      plot = 1'b0;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return vga_hs;
         1:       return vga_vs;
         default: return vga_blank_n;
      endcase
   endfunction

   task automatic wait_sig(input int sel, input logic lvl, output int t, output bit ok);
      ok = 0;
      for (int i = 0; i < 2 * FRAME_CLK; i++) begin
         if (sig(sel) === lvl) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      t = cyc;
   endtask

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      int f, p, e, t0, t1, t2, tx;
      bit ok, okall;
      plot = 0; x = 0; y = 0; colour = 0; resetn = 1;
      #1 resetn = 0;
      repeat (3) @(negedge clk);
      resetn = 1;

      // A plot during CLEAR must not stick.
      wait_cyc(100);
      do_plot(0, 0, 3'b111);

      for (int i = 0; i < CLEAR_CLK + 100 && ready !== 1'b1; i++) @(negedge clk);
      check("ready_rise", 37'(cyc), 37'(CLEAR_CLK));

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
         end else begin
            int rx, ry;
            rx = ($urandom_range(0, 5) == 0) ? 160 + $urandom_range(0, 95) : $urandom_range(0, 19);
            ry = ($urandom_range(0, 5) == 0) ? 120 + $urandom_range(0, 7)  : $urandom_range(0, 9);
            do_plot(rx, ry, 3'($urandom_range(0, 7)));
         end
      end
      do_plot(10, 5, 3'b110);
      do_plot(160, 0, 3'b111);
      do_plot(0, 120, 3'b111);
      do_plot(7, 3, 3'b010);

      // Collision: overwrite (7,3) on the edge of its last read this frame.
      f = cyc / FRAME_CLK + 1;
      p = f * FRAME_PIX + 15 * H_TOT + 31;
      e = 2 * p + 2;
      wait_cyc(e - 1);
      do_plot(7, 3, 3'b101);
      wait_cyc(e + 2);
      check("coll_old", 37'({vga_r[0], vga_g[0], vga_b[0]}), 37'(3'b010));
      p = f * FRAME_PIX + 20 * H_TOT + 40;
      wait_cyc(2 * p + 4);
      check("single_write", 37'({vga_r, vga_g, vga_b}), 37'({10'h3FF, 10'h3FF, 10'h000}));
      wait_cyc(e + 2 + FRAME_CLK);
      check("coll_new", 37'({vga_r[0], vga_g[0], vga_b[0]}), 37'(3'b101));

      okall = 1;
      wait_sig(1, 1'b1, tx, ok); okall &= ok;
      wait_sig(1, 1'b0, t0, ok); okall &= ok;
      wait_sig(1, 1'b1, t1, ok); okall &= ok;
      wait_sig(1, 1'b0, t2, ok); okall &= ok;
      check("vs_low", 37'(t1 - t0), 37'(2 * V_SYNC * H_TOT));
      check("vs_period", 37'(t2 - t0), 37'(FRAME_CLK));
      $display("vs low %0d clk, period %0d clk", t1 - t0, t2 - t0);
      wait_sig(0, 1'b1, tx, ok); okall &= ok;
      wait_sig(0, 1'b0, t0, ok); okall &= ok;
      wait_sig(0, 1'b1, t1, ok); okall &= ok;
      wait_sig(0, 1'b0, t2, ok); okall &= ok;
      check("hs_low", 37'(t1 - t0), 37'(2 * H_SYNC));
      check("hs_period", 37'(t2 - t0), 37'(2 * H_TOT));
      $display("hs low %0d clk, period %0d clk", t1 - t0, t2 - t0);
      wait_sig(2, 1'b0, tx, ok); okall &= ok;
      wait_sig(2, 1'b1, t0, ok); okall &= ok;
      wait_sig(2, 1'b0, t1, ok); okall &= ok;
      check("blank_high", 37'(t1 - t0), 37'(2 * H_VIS));
      check("sync_waits", 37'(okall), 37'(1));

      // Reset mid-frame at v=20, h=30, between clock edges.
      f = cyc / FRAME_CLK;
      if (2 * (f * FRAME_PIX + 20 * H_TOT + 30) + 1 <= cyc + 2) f++;
      wait_cyc(2 * (f * FRAME_PIX + 20 * H_TOT + 30) + 1);
      check("pre_reset_ready", 37'(ready), 37'(1));
      #3 resetn = 0;
      #1 check("async_reset", obs, RESET_VEC);
      repeat (3) @(negedge clk);
      resetn = 1;

      wait_cyc(CLEAR_CLK - 1);
      check("reclear_busy", 37'(ready), 37'(0));
      wait_cyc(CLEAR_CLK);
      check("reclear_done", 37'(ready), 37'(1));
      p = 3 * FRAME_PIX + 20 * H_TOT + 40;
      wait_cyc(2 * p + 4);
      check("post_clear_pixel", 37'({vga_blank_n, vga_r, vga_g, vga_b}),
            37'({1'b1, {10{BG[2]}}, {10{BG[1]}}, {10{BG[0]}}}));
      wait_cyc(4 * FRAME_CLK);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pixel_fb_scanout.md
# pixel_fb_scanout

Receiving end of the pixel-write stream that the game's renderer produces. Accepts `plot`/`x`/`y`/`colour` writes into a 160x120, 3-bit-per-pixel on-chip frame buffer. Independently scans the buffer out as 640x480@60 Hz VGA, with each stored pixel replicated 4x4. Sits between the renderer and the board's VGA DAC pins, replacing the opaque adapter with a block the team owns and verifies.

## Interface
Parameters:
- `BG_COLOUR`, 3'b000: colour written to every location during the post-reset clear.
- `H_VIS`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing, in pixel periods.
- `V_VIS`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing, in lines.

Ports:
- `clk`  in  1: 50 MHz system clock. Only clock.
- `resetn`  in  1: asynchronous, active-low reset.
- `plot`  in  1: write strobe, sampled every clk.
- `x`  in  8: write column, 0..159.
- `y`  in  7: write row, 0..119.
- `colour`  in  3: {R,G,B} write data.
- `ready`  out  1: high in RUN state; writes are accepted only while high.
- `frame_done`  out  1: one-clk pulse at the first pixel period of vertical front porch.
- `vga_clk`  out  1: clk/2, 25 MHz pixel clock.
- `vga_hs`  out  1: horizontal sync, active low.
- `vga_vs`  out  1: vertical sync, active low.
- `vga_blank_n`  out  1: high during the visible region.
- `vga_sync_n`  out  1: tied 1.
- `vga_r`/`vga_g`/`vga_b`  out  10 each: channel bit replicated to all 10 bits.

## Operation
- Frame buffer:
  - 19200 x 3 bits, dual-port (one write port, one read port).
  - Address = y*160 + x, computed as (y<<7)+(y<<5)+x, 15 bits.
- FSM states: CLEAR, RUN.
  - Reset enters CLEAR with the clear address at 0.
  - CLEAR writes `BG_COLOUR` at the clear address every clk and increments it. After writing address 19199, next state is RUN.
  - CLEAR: `ready`=0, `plot` ignored, `vga_blank_n` forced 0, RGB forced 0. Sync generation continues normally.
  - RUN: `plot`=1 with x<160 and y<120 writes `colour` on that clk edge. Out-of-range writes are dropped silently, with no wrap-around.
- Scan counters:
  - `pix_en` toggles every clk (high on alternate cycles, 0 after reset). `vga_clk` equals registered `pix_en`.
  - h counts 0..799 on `pix_en` and wraps to 0. v increments when h wraps, counts 0..524, and wraps to 0.
  - hs low for h in 656..751. vs low for v in 490..491. Visible region is h<640 and v<480.
- Read address = (v>>2)*160 + (h>>2), valid only in the visible region.
- Collision: a write and a read to the same address on the same clk return the OLD data; the new value appears on the next frame.
- `frame_done` pulses for exactly one clk when h=0, v=480 is first reached (on the `pix_en` clk). Renderers use it as the update tick.
- Reset mid-frame: all counters, the FSM and the outputs return to reset values immediately (asynchronously). CLEAR restarts from address 0.

## Timing
- Reset values: `ready`=0, `frame_done`=0, `vga_clk`=0, `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0, RGB=0, `vga_sync_n`=1, h=0, v=0.
- Write latency: data is stored on the clk edge where `plot`=1 and `ready`=1. One write per clk is sustained, with no backpressure beyond `ready`.
- Scan pipeline: hs/vs/blank_n/RGB update only on `pix_en` clks and reflect the counter values of the previous pixel period, i.e. 2 clk latency.
  - The sync and blank outputs are delayed to match the RAM read, so all five outputs stay mutually aligned.
- CLEAR duration: exactly 19200 clk from reset release. `ready` rises on clk 19200 after release.
- Line = 1600 clk. Frame = 840000 clk. The `frame_done` period is 840000 clk.

## Test plan
- Reset/clear: assert `resetn`=0 for 3 clk, then release.
  - All outputs must hold reset values during reset.
  - `ready` = 0 for 19200 clk, then 1.
  - The first frame's visible pixels are `BG_COLOUR`.
- Single write: after `ready`, plot x=10, y=5, colour=3'b110.
  - Next frame: RGB=1,1,0 (r/g = 10'h3FF, b = 0) exactly for h=40..43 and v=20..23.
  - All other pixels are `BG_COLOUR`.
- Out-of-range: plot x=160, y=0 and x=0, y=120 with colour 3'b111. No location changes: the full-frame pixel compare matches the expected image.
- Sync timing: measure over 2 frames.
  - hs low width 192 clk, hs period 1600 clk.
  - vs low width 3200 clk, vs period 840000 clk.
  - `blank_n` high 1280 clk per visible line and 0 on lines 480..524.
- Collision: in the clk where read address = 100 is issued, plot to address 100 with a new colour. The current frame shows the old colour; the next frame shows the new one.
- Reset mid-frame: assert `resetn` at v=200, h=300.
  - Outputs return to reset values asynchronously.
  - After release, CLEAR repeats (`ready`=0 for 19200 clk) and h/v restart at 0.
